// File: rtl/alarm_set_ctrl.sv
// Time-setting and alarm controller: held buttons become auto-repeating steps
// that go to the time counter or to the alarm registers, plus alarm match and buzzer tone.
//   state      | meaning
//   B_IDLE     | no button active, waiting for a rising edge
//   B_DELAY    | step issued, holding out the initial repeat delay
//   B_REPEAT   | auto-repeat, one step per REPEAT_RATE cycles
//   B_WAIT_REL | steps suppressed until both buttons are released
//   A_IDLE     | alarm quiet, watching for a match on a 1 Hz tick
//   A_RING     | alarm ringing, buzzer active
module alarm_set_ctrl #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 20_000_000,
  parameter int RING_SECS    = 60,
  parameter int TONE_DIV     = 50_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       tick_hr,
  input  logic       tick_min,
  input  logic       set_alarm,
  input  logic       alarm_en,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       inc_hr,
  output logic       inc_min,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       buzzer
);

  typedef enum logic [1:0] {B_IDLE, B_DELAY, B_REPEAT, B_WAIT_REL} bstate_t;
  typedef enum logic {A_IDLE, A_RING} astate_t;

  bstate_t     r_bstate, w_bnext;
  astate_t     r_astate, w_anext;
  logic        r_hr_q, r_min_q, r_sel_hr, r_mode;
  logic [31:0] r_rep_cnt, r_ring_cnt, r_tone_cnt;
  logic        r_buzzer, r_inc_hr, r_inc_min;
  logic [4:0]  r_alarm_hr;
  logic [5:0]  r_alarm_min;

  logic        w_hr_rise, w_min_rise, w_any_rise, w_ringing, w_dismiss, w_trigger;
  logic        w_act_held, w_step, w_sel_nxt;
  logic [31:0] w_rep_nxt, w_ring_nxt;

  assign w_hr_rise  = tick_hr & ~r_hr_q;
  assign w_min_rise = tick_min & ~r_min_q;
  assign w_any_rise = w_hr_rise | w_min_rise;
  assign w_ringing  = (r_astate == A_RING);
  // A button edge while ringing only silences the alarm; it never steps.
  assign w_dismiss  = w_ringing & w_any_rise;
  assign w_trigger  = (r_astate == A_IDLE) & tick_1hz & alarm_en & ~set_alarm &
                      (cur_hr == r_alarm_hr) & (cur_min == r_alarm_min) & (cur_sec == 6'd0);
  assign w_act_held = r_sel_hr ? tick_hr : tick_min;

  always_comb begin
    w_bnext   = r_bstate;
    w_step    = 1'b0;
    w_sel_nxt = r_sel_hr;
    w_rep_nxt = r_rep_cnt;
    case (r_bstate)
      B_IDLE: begin
        if (w_dismiss) begin
          w_bnext = B_WAIT_REL;
        end else if (w_any_rise) begin
          w_step    = 1'b1;
          w_sel_nxt = w_hr_rise;
          w_rep_nxt = 32'(REPEAT_DELAY - 1);
          w_bnext   = B_DELAY;
        end
      end
      B_DELAY, B_REPEAT: begin
        if (!w_act_held) begin
          w_bnext = B_IDLE;
        end else if (w_dismiss || (set_alarm != r_mode)) begin
          w_bnext = B_WAIT_REL;
        end else if (r_rep_cnt == '0) begin
          w_step    = 1'b1;
          w_rep_nxt = 32'(REPEAT_RATE - 1);
          w_bnext   = B_REPEAT;
        end else begin
          w_rep_nxt = r_rep_cnt - 32'd1;
        end
      end
      default: begin
        if (!tick_hr && !tick_min) w_bnext = B_IDLE;
      end
    endcase
  end

  always_comb begin
    w_anext    = r_astate;
    w_ring_nxt = r_ring_cnt;
    case (r_astate)
      A_IDLE: begin
        if (w_trigger) begin
          w_anext    = A_RING;
          w_ring_nxt = '0;
        end
      end
      default: begin
        if (!alarm_en || set_alarm || w_any_rise ||
            (tick_1hz && (r_ring_cnt == 32'(RING_SECS - 1)))) begin
          w_anext = A_IDLE;
        end else if (tick_1hz) begin
          w_ring_nxt = r_ring_cnt + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_bstate    <= B_IDLE;
      r_astate    <= A_IDLE;
      r_hr_q      <= 1'b0;
      r_min_q     <= 1'b0;
      r_sel_hr    <= 1'b0;
      r_mode      <= 1'b0;
      r_rep_cnt   <= '0;
      r_ring_cnt  <= '0;
      r_tone_cnt  <= '0;
      r_buzzer    <= 1'b0;
      r_inc_hr    <= 1'b0;
      r_inc_min   <= 1'b0;
      r_alarm_hr  <= '0;
      r_alarm_min <= '0;
    end else begin
      r_bstate   <= w_bnext;
      r_astate   <= w_anext;
      r_hr_q     <= tick_hr;
      r_min_q    <= tick_min;
      r_sel_hr   <= w_sel_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_ring_cnt <= w_ring_nxt;
      if (r_bstate == B_IDLE) r_mode <= set_alarm;
      r_inc_hr  <= w_step & w_sel_nxt & ~set_alarm;
      r_inc_min <= w_step & ~w_sel_nxt & ~set_alarm;
      if (w_step && set_alarm) begin
        if (w_sel_nxt) r_alarm_hr <= (r_alarm_hr == 5'd23) ? 5'd0 : r_alarm_hr + 5'd1;
        else r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
      end
      // Tone phase restarts on ring entry so the first toggle is always to 1.
      if (w_anext == A_RING) begin
        if (r_astate == A_IDLE) begin
          r_tone_cnt <= 32'(TONE_DIV - 1);
          r_buzzer   <= 1'b0;
        end else if (r_tone_cnt == '0) begin
          r_tone_cnt <= 32'(TONE_DIV - 1);
          r_buzzer   <= ~r_buzzer;
        end else begin
          r_tone_cnt <= r_tone_cnt - 32'd1;
        end
      end else begin
        r_tone_cnt <= '0;
        r_buzzer   <= 1'b0;
      end
    end
  end

  assign inc_hr    = r_inc_hr;
  assign inc_min   = r_inc_min;
  assign alarm_hr  = r_alarm_hr;
  assign alarm_min = r_alarm_min;
  assign ringing   = w_ringing;
  assign buzzer    = r_buzzer;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Self-checking bench for alarm_set_ctrl: directed steps plus randomized button holds
// checked against an arithmetic model of repeat counts and alarm register wrap.
module tb_alarm_set_ctrl;
  localparam int D = 8;
  localparam int R = 4;
  localparam int RS = 3;
  localparam int TD = 5;

  logic clk, reset_n, tick_1hz, tick_hr, tick_min, set_alarm, alarm_en;
  logic [4:0] cur_hr;
  logic [5:0] cur_min, cur_sec;
  logic inc_hr, inc_min, ringing, buzzer;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int cnt_hr = 0;
  int cnt_min = 0;
  int q_off[$];
  int m_hr, m_min;

  alarm_set_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .RING_SECS(RS), .TONE_DIV(TD)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .tick_hr(tick_hr),
    .tick_min(tick_min), .set_alarm(set_alarm), .alarm_en(alarm_en), .cur_hr(cur_hr),
    .cur_min(cur_min), .cur_sec(cur_sec), .inc_hr(inc_hr), .inc_min(inc_min),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .ringing(ringing), .buzzer(buzzer));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (inc_hr === 1'b1) cnt_hr++;
    if (inc_min === 1'b1) begin
      cnt_min++;
      q_off.push_back(cyc - t0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps produced by holding a button n sampled cycles: one at press, one after the
  // repeat delay, then one per repeat period.
  function automatic int exp_pulses(input int n);
    if (n < 1) return 0;
    if (n < 1 + D) return 1;
    return 2 + (n - 1 - D) / R;
  endfunction

  task automatic zero_counts();
    cnt_hr = 0;
    cnt_min = 0;
    q_off.delete();
  endtask

  // btn: 0 = minute, 1 = hour, 2 = both
  task automatic press_hold(input int btn, input int n);
    if (btn != 1) tick_min = 1'b1;
    if (btn != 0) tick_hr = 1'b1;
    t0 = cyc;
    cyc_n(n);
    tick_hr = 1'b0;
    tick_min = 1'b0;
    cyc_n(3);
  endtask

  task automatic pulse_1hz();
    tick_1hz = 1'b1;
    cyc_n(1);
    tick_1hz = 1'b0;
  endtask

  initial begin
    int mode, btn, n, p, e;
    reset_n = 1'b0; tick_1hz = 1'b0; tick_hr = 1'b0; tick_min = 1'b0;
    set_alarm = 1'b0; alarm_en = 1'b0; cur_hr = '0; cur_min = '0; cur_sec = '0;
    cyc_n(3);
    check("rst_inc", {inc_hr, inc_min}, 0);
    check("rst_alarm", {alarm_hr, alarm_min}, 0);
    check("rst_ring", {ringing, buzzer}, 0);
    reset_n = 1'b1;
    cyc_n(2);

    // Auto-repeat timing on the minute button
    zero_counts();
    press_hold(0, 30);
    check("rep_count", cnt_min, 7);
    check("rep_qsize", q_off.size(), exp_pulses(30));
    for (int k = 0; k < q_off.size(); k++) begin
      e = (k == 0) ? 1 : 1 + D + (k - 1) * R;
      check("rep_offset", q_off[k], e);
    end
    cyc_n(10);
    check("rep_after_rel", cnt_min, 7);
    check("rep_no_hr", cnt_hr, 0);

    // Alarm editing and wrap
    set_alarm = 1'b1;
    cyc_n(2);
    zero_counts();
    for (int k = 0; k < 25; k++) press_hold(1, 1);
    check("set_hr_wrap", alarm_hr, 1);
    for (int k = 0; k < 61; k++) press_hold(0, 1);
    check("set_min_wrap", alarm_min, 1);
    check("set_min_nocarry", alarm_hr, 1);
    check("set_no_inc", cnt_hr + cnt_min, 0);
    press_hold(2, 1 + D + R);
    check("both_hr", alarm_hr, (1 + exp_pulses(1 + D + R)) % 24);
    check("both_min", alarm_min, 1);
    m_hr = (1 + exp_pulses(1 + D + R)) % 24;
    m_min = 1;

    // Randomized holds against the model
    for (int it = 0; it < 12; it++) begin
      mode = $urandom_range(0, 1);
      btn = $urandom_range(0, 2);
      n = $urandom_range(1, 24);
      set_alarm = mode[0];
      cyc_n(2);
      zero_counts();
      press_hold(btn, n);
      p = exp_pulses(n);
      if (mode == 1) begin
        if (btn != 0) m_hr = (m_hr + p) % 24;
        else m_min = (m_min + p) % 60;
      end
      check("rnd_inc_hr", cnt_hr, (mode == 0 && btn != 0) ? p : 0);
      check("rnd_inc_min", cnt_min, (mode == 0 && btn == 0) ? p : 0);
      check("rnd_alarm_hr", alarm_hr, m_hr);
      check("rnd_alarm_min", alarm_min, m_min);
    end

    // Program 06:30
    set_alarm = 1'b1;
    cyc_n(2);
    n = (6 - m_hr + 24) % 24;
    for (int k = 0; k < n; k++) press_hold(1, 1);
    n = (30 - m_min + 60) % 60;
    for (int k = 0; k < n; k++) press_hold(0, 1);
    check("prog_hr", alarm_hr, 6);
    check("prog_min", alarm_min, 30);

    // Trigger, tone and auto-stop
    set_alarm = 1'b0; alarm_en = 1'b1;
    cur_hr = 5'd6; cur_min = 6'd30; cur_sec = 6'd0;
    cyc_n(2);
    check("pre_trig", ringing, 0);
    pulse_1hz();
    check("trig_ring", ringing, 1);
    check("trig_buz0", buzzer, 0);
    for (int j = 1; j < 20; j++) begin
      cyc_n(1);
      check("tone", buzzer, (j / TD) % 2);
    end
    cur_sec = 6'd5;
    for (int k = 1; k <= RS; k++) begin
      pulse_1hz();
      check("ring_tick", ringing, (k < RS) ? 1 : 0);
      cyc_n(2);
    end
    check("stop_buz", buzzer, 0);

    // Dismiss with hour button
    cur_sec = 6'd0;
    pulse_1hz();
    cur_sec = 6'd5;
    check("retrig", ringing, 1);
    cyc_n(3);
    zero_counts();
    tick_hr = 1'b1;
    cyc_n(1);
    check("dismiss_ring", ringing, 0);
    cyc_n(14);
    tick_hr = 1'b0;
    cyc_n(3);
    check("dismiss_noinc", cnt_hr, 0);
    check("dismiss_alarm_hr", alarm_hr, 6);
    press_hold(1, 1);
    check("after_dismiss_step", cnt_hr, 1);

    // Dismiss with alarm_en
    cur_sec = 6'd0;
    pulse_1hz();
    cur_sec = 6'd5;
    check("retrig2", ringing, 1);
    cyc_n(3);
    alarm_en = 1'b0;
    cyc_n(1);
    check("en_off_ring", ringing, 0);
    check("en_off_buz", buzzer, 0);
    alarm_en = 1'b1;

    // No false triggers
    cur_sec = 6'd1;
    pulse_1hz();
    check("nf_sec1", ringing, 0);
    cur_sec = 6'd0; set_alarm = 1'b1;
    pulse_1hz();
    check("nf_setal", ringing, 0);
    set_alarm = 1'b0; alarm_en = 1'b0;
    pulse_1hz();
    check("nf_dis", ringing, 0);
    alarm_en = 1'b1; cur_sec = 6'd5;
    cyc_n(2);

    // Mode change while held
    zero_counts();
    tick_min = 1'b1;
    cyc_n(3);
    set_alarm = 1'b1;
    cyc_n(17);
    tick_min = 1'b0;
    cyc_n(3);
    check("mode_inc_min", cnt_min, 1);
    check("mode_alarm_min", alarm_min, 30);
    set_alarm = 1'b0;
    cyc_n(2);

    // Trigger and button edge together, then reset mid-ring and mid-repeat
    zero_counts();
    cur_sec = 6'd0;
    tick_1hz = 1'b1; tick_hr = 1'b1;
    cyc_n(1);
    tick_1hz = 1'b0; cur_sec = 6'd5;
    check("sim_ring", ringing, 1);
    check("sim_inc_hr", inc_hr, 1);
    cyc_n(7);
    check("sim_hold_cnt", cnt_hr, exp_pulses(8));
    check("sim_ring_held", ringing, 1);
    check("sim_buz", buzzer, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ring", {ringing, buzzer}, 0);
    check("rst_mid_alarm", {alarm_hr, alarm_min}, 0);
    check("rst_mid_inc", {inc_hr, inc_min}, 0);
    tick_hr = 1'b0;
    cyc_n(2);
    reset_n = 1'b1;
    zero_counts();
    cyc_n(20);
    check("post_rst_pulses", cnt_hr + cnt_min, 0);
    check("post_rst_ring", ringing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alarm_set_ctrl.md
Name: alarm_set_ctrl

Overview:
- Controller for the digital clock's time-setting and alarm path.
- Turns held hour/minute buttons into auto-repeating increment pulses. Routes each pulse either to the external timekeeping counter or to the block's own alarm hour/minute registers.
- Compares the running time against the stored alarm and drives the buzzer tone.
- Sits between the button synchronisers and the time counter / VGA display in the top-level clock.

Parameters:
- REPEAT_DELAY, 50_000_000: cycles a button is held before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_RATE, 20_000_000: cycles between auto-repeat pulses.
- RING_SECS, 60: number of tick_1hz pulses the alarm rings before stopping on its own.
- TONE_DIV, 50_000: cycles per buzzer half-period (1 kHz tone).

Ports:
- clk_100MHz, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- tick_1hz, input, 1: one-cycle pulse once per second, from the time counter.
- tick_hr, input, 1: synchronised hour button level.
- tick_min, input, 1: synchronised minute button level.
- set_alarm, input, 1: level. 1 = buttons edit the alarm; 0 = buttons edit the time.
- alarm_en, input, 1: alarm armed.
- cur_hr, input, 5: current hour, 0-23.
- cur_min, input, 6: current minute, 0-59.
- cur_sec, input, 6: current second, 0-59.
- inc_hr, output, 1: one-cycle pulse; increments the time hour.
- inc_min, output, 1: one-cycle pulse; increments the time minute.
- alarm_hr, output, 5: stored alarm hour.
- alarm_min, output, 6: stored alarm minute.
- ringing, output, 1: alarm currently ringing.
- buzzer, output, 1: tone output.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All outputs 0, including alarm_hr and alarm_min.
  - Both FSMs go to their idle states; all counters clear.
- Button FSM, states B_IDLE, B_DELAY, B_REPEAT, B_WAIT_REL:
  - B_IDLE: on a 0->1 of tick_hr or tick_min, emit one step in the next cycle and go to B_DELAY. The step is emitted 1 cycle after the rising edge is registered.
  - If both buttons are high, hour wins. The minute button is ignored until both buttons are released.
  - B_DELAY: counts REPEAT_DELAY cycles, then emits a step and goes to B_REPEAT.
  - B_REPEAT: emits a step every REPEAT_RATE cycles.
  - In any state, releasing the active button returns to B_IDLE with no pulse.
  - If set_alarm changes while a button is held, go to B_WAIT_REL with no further steps. B_WAIT_REL returns to B_IDLE once both buttons are 0.
- Step routing:
  - set_alarm=0: the step is an inc_hr or inc_min pulse. Wrap is handled by the external counter.
  - set_alarm=1: no inc pulse. alarm_hr increments 23->0, or alarm_min increments 59->0. A minute wrap does not carry into the hour.
- Alarm FSM, states A_IDLE, A_RING:
  - Trigger condition: A_IDLE and tick_1hz=1 and alarm_en=1 and set_alarm=0 and cur_hr==alarm_hr and cur_min==alarm_min and cur_sec==0.
  - On trigger, go to A_RING: ringing=1 from the next cycle and the seconds counter clears.
  - A_RING counts tick_1hz pulses.
  - Leave A_RING for A_IDLE, with ringing=0 in the next cycle, on any of:
    - count reaches RING_SECS;
    - alarm_en=0;
    - set_alarm=1;
    - a rising edge on tick_hr or tick_min.
  - A dismissing button edge is consumed: the button FSM goes to B_WAIT_REL, and no step or inc pulse is produced.
  - Retrigger can only occur at the next matching sec==0 tick, i.e. 24 h later, or sooner if the alarm time is edited.
- Buzzer:
  - While ringing=1, buzzer toggles every TONE_DIV cycles. The tone counter restarts at ring entry and the first toggle is to 1.
  - buzzer=0 whenever ringing=0.
- Simultaneous tick_1hz trigger and button edge in the same cycle: the trigger is taken and the button step proceeds normally. Dismissal only applies to edges that occur while in A_RING.
- Reset asserted mid-ring or mid-repeat: immediate return to reset values, with no glitch pulse after release.

Test Plan:
- Auto-repeat timing: REPEAT_DELAY=8, REPEAT_RATE=4, set_alarm=0, hold tick_min for 30 cycles -> inc_min pulses at edge+1, +9, +13, +17, +21, +25, +29. Release -> no further pulses; inc_hr never pulses.
- Alarm setting and wrap: set_alarm=1, 25 hour steps and 61 minute steps -> alarm_hr=1, alarm_min=1, no inc pulses. Both buttons held -> only alarm_hr changes.
- Trigger and auto-stop: alarm 06:30, alarm_en=1, drive cur=06:30:00 with tick_1hz -> ringing=1 the next cycle. With TONE_DIV=5, buzzer toggles every 5 cycles. RING_SECS=3: after 3 ticks, ringing=0 and buzzer=0.
- Dismiss: while ringing, tick_hr edge -> ringing=0, no inc_hr pulse, no step until release. Separately, drop alarm_en while ringing -> ringing=0 the next cycle.
- No false trigger: match with cur_sec=1, or with set_alarm=1, or with alarm_en=0 -> ringing stays 0.
- Mode change and reset: toggle set_alarm while tick_min is held -> pulses stop until release. Pull reset_n low mid-ring -> ringing, buzzer, alarm_hr and alarm_min all 0 immediately.
